vga_tile_mem_arbiter: RTL and testbench
=======================================

Name: vga_tile_mem_arbiter

Overview:
- Shares one single-port, 1-cycle-latency tile RAM between two requesters.
  - The VGA display fetch path, which reads tile codes during scan-out and always has priority.
  - The snake game logic, which writes tile updates through a small internal FIFO.
- Also sequences a whole-RAM clear on request, for game restart.
- Runs on the 25 MHz pixel clock, clkdiv[1], between the game core and VGA_display.

Parameters:
ADDR_W, 11, tile RAM address width; RAM depth is 2^ADDR_W.
DATA_W, 4, tile code width.
FIFO_DEPTH, 4, write FIFO entries; must be a power of 2 and at least 2.
CLR_VAL, 0, tile code written to every address during a clear.
STALL_LIMIT, 1023, consecutive starved cycles before stall_flag sets.

Ports:
clk  in  1  pixel clock; all logic on the rising edge.
RSTN  in  1  synchronous active-low reset.
rd_req  in  1  display read request, one address per cycle.
rd_addr  in  ADDR_W  display read address.
rd_valid  out  1  rd_data valid; the read result, 1 cycle after rd_req.
rd_data  out  DATA_W  equals mem_rdata.
wr_valid  in  1  game write offer.
wr_ready  out  1  FIFO can accept.
wr_addr  in  ADDR_W  write address.
wr_data  in  DATA_W  write data.
clr_req  in  1  pulse; start a full-RAM clear.
clr_busy  out  1  clear in progress.
in_blank  in  1  display in blanking interval.
stall_flag  out  1  sticky; write FIFO starved for STALL_LIMIT cycles.
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
mem_en  out  1  RAM enable.
mem_we  out  1  RAM write enable.
mem_addr  out  ADDR_W  RAM address.
mem_wdata  out  DATA_W  RAM write data.
mem_rdata  in  DATA_W  RAM read data; registered, valid 1 cycle after mem_en with mem_we low.

Behaviour:
- Reset (RSTN low at an edge):
  - Outputs: rd_valid=0, wr_ready=0, clr_busy=0, stall_flag=0, fifo_level=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - State returns to IDLE and the FIFO is emptied.
  - Reset mid-clear aborts the clear; the RAM contents are left partially cleared.
- RAM drive: mem_en, mem_we, mem_addr and mem_wdata are combinational from the per-cycle grant.
- Grant priority each cycle, highest first:
  - Display read: rd_req=1 gives mem_en=1, mem_we=0, mem_addr=rd_addr. A display read is never stalled.
  - Clear write: in CLEAR with rd_req=0, write CLR_VAL at clr_cnt.
  - FIFO write: in IDLE with rd_req=0, FIFO non-empty and the write gate open, pop the head and write it.
  - Otherwise mem_en=0.
- Read latency: rd_valid is a register equal to rd_req of the previous cycle.
- Write FIFO:
  - wr_ready = (fifo_level < FIFO_DEPTH) and RSTN is high, taken from the registered count.
  - A push occurs when wr_valid && wr_ready.
  - A push and a pop in the same cycle are both allowed; the level is unchanged.
  - When full, wr_ready=0 even if a pop happens in that cycle.
  - Order is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
- State machine (2 states):
  - IDLE -> CLEAR when clr_req=1. clr_cnt is set to 0 and clr_busy goes to 1 on the next cycle.
  - CLEAR: clr_cnt increments only on cycles where the clear write is granted.
  - CLEAR -> IDLE after the write at address 2^ADDR_W-1 is granted; clr_busy drops on the same edge.
  - clr_req while in CLEAR is ignored.
  - The FIFO keeps accepting pushes during CLEAR but does not pop. Queued writes drain after the clear, so they overwrite cleared tiles.
- Stall counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs, including cycles spent in CLEAR.
  - Resets to 0 on a pop or when the FIFO is empty.
  - Saturates. stall_flag sets when the counter reaches STALL_LIMIT and stays set until reset.
- Address and data widths pass through unchanged; there is no truncation.

Optional Feature:
VBLANK_ONLY_EN.
- Defined: the FIFO write gate is open only when in_blank=1, giving tear-free updates. Clear writes are not gated.
- Undefined: the write gate is always open, so FIFO writes take any cycle with rd_req=0.

Test Plan:
1. Reset values: hold RSTN=0 for 3 cycles with wr_valid=1, rd_req=1 -> all outputs stay at their reset values, including wr_ready=0 and mem_en=0. After release, wr_ready=1 on the next cycle.
2. Read latency: rd_req=1, rd_addr=5, RAM[5]=9 -> mem_addr=5 and mem_we=0 that cycle; next cycle rd_valid=1, rd_data=9.
3. Read/write conflict: push (addr 3, data 7) while rd_req=1 for 4 cycles -> no write for those 4 cycles; on the first rd_req=0 cycle mem_we=1, mem_addr=3, mem_wdata=7, fifo_level goes 1->0.
4. FIFO backpressure: rd_req held at 1, push 5 writes -> the first 4 are accepted, then wr_ready=0 and fifo_level=4. Release rd_req -> writes drain in push order on 4 consecutive cycles.
5. Clear sequence: ADDR_W=4, clr_req pulse, rd_req=0, one push mid-clear -> 16 consecutive writes of CLR_VAL to addresses 0..15, clr_busy high for 16 cycles, then the pushed write lands. A clr_req at cycle 8 of the clear has no effect.
6. Optional gate and stall: VBLANK_ONLY_EN defined, STALL_LIMIT=8, one push, in_blank=0 -> no write and stall_flag=1 after 8 cycles. Then in_blank=1 -> the write issues and stall_flag stays 1.

Source files
------------

// File: rtl/vga_tile_mem_arbiter.sv
// ============================================================================
// Module   : vga_tile_mem_arbiter
// Brief    : Tile RAM arbiter: display reads first, then clear, then FIFO writes.
//            Optional VBLANK_ONLY_EN limits FIFO writes to the blanking interval.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_tile_mem_arbiter #(
  parameter int               ADDR_W      = 11,
  parameter int               DATA_W      = 4,
  parameter int               FIFO_DEPTH  = 4,
  parameter logic [DATA_W-1:0] CLR_VAL    = '0,
  parameter int               STALL_LIMIT = 1023
) (
  input  logic                          clk,
  input  logic                          RSTN,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          clr_req,
  output logic                          clr_busy,
  input  logic                          in_blank,
  output logic                          stall_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W   = c_PTR_W + 1;
  localparam int c_STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [c_LVL_W-1:0]   c_FULL      = c_LVL_W'(FIFO_DEPTH);
  localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'(STALL_LIMIT);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_clr_cnt;
  logic [c_LVL_W-1:0]     r_level;
  logic [c_PTR_W-1:0]     r_wr_ptr;
  logic [c_PTR_W-1:0]     r_rd_ptr;
  logic [c_STALL_W-1:0]   r_stall_cnt;
  logic                   r_stall_flag;
  logic                   r_rd_valid;
  logic [ADDR_W-1:0]      r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]      r_fifo_data [FIFO_DEPTH];

  logic                   w_gate;
  logic                   w_gnt_rd;
  logic                   w_gnt_clr;
  logic                   w_pop;
  logic                   w_push;
  logic [c_STALL_W-1:0]   w_stall_nxt;

`ifdef VBLANK_ONLY_EN
  assign w_gate = in_blank;
`else
  logic w_unused_in_blank;
  assign w_unused_in_blank = in_blank;
  assign w_gate            = 1'b1;
`endif

  // Grants are qualified by RSTN so the RAM stays idle while reset is held.
  assign w_gnt_rd  = RSTN && rd_req;
  assign w_gnt_clr = RSTN && !rd_req && (r_state == ST_CLEAR);
  assign w_pop     = RSTN && !rd_req && (r_state == ST_IDLE) &&
                     (r_level != '0) && w_gate;
  assign w_push    = wr_valid && wr_ready;

  assign wr_ready   = RSTN && (r_level != c_FULL);
  assign fifo_level = r_level;
  assign clr_busy   = (r_state == ST_CLEAR);
  assign stall_flag = r_stall_flag;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = mem_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_rd) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (w_gnt_clr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_clr_cnt;
      mem_wdata = CLR_VAL;
    end else if (w_pop) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_fifo_addr[r_rd_ptr];
      mem_wdata = r_fifo_data[r_rd_ptr];
    end
  end

  always_comb begin
    w_stall_nxt = r_stall_cnt;
    if ((r_level == '0) || w_pop)
      w_stall_nxt = '0;
    else if (r_stall_cnt != c_STALL_MAX)
      w_stall_nxt = r_stall_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= wr_addr;
      r_fifo_data[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_state      <= ST_IDLE;
      r_clr_cnt    <= '0;
      r_level      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_stall_cnt  <= '0;
      r_stall_flag <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      r_stall_cnt <= w_stall_nxt;
      if (w_stall_nxt == c_STALL_MAX) r_stall_flag <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (clr_req) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (w_gnt_clr) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == '1) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_tile_mem_arbiter.sv
// ============================================================================
// Module   : tb_vga_tile_mem_arbiter
// Brief    : Scoreboard bench for vga_tile_mem_arbiter with a 1-cycle RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_tile_mem_arbiter;

  localparam int         c_AW  = 4;
  localparam int         c_DW  = 4;
  localparam logic [3:0] c_CLR = 4'hC;

  logic            clk = 1'b0;
  logic            RSTN;
  logic            rd_req, rd_valid;
  logic [c_AW-1:0] rd_addr;
  logic [c_DW-1:0] rd_data;
  logic            wr_valid, wr_ready;
  logic [c_AW-1:0] wr_addr;
  logic [c_DW-1:0] wr_data;
  logic            clr_req, clr_busy, in_blank, stall_flag;
  logic [2:0]      fifo_level;
  logic            mem_en, mem_we;
  logic [c_AW-1:0] mem_addr;
  logic [c_DW-1:0] mem_wdata;
  logic [c_DW-1:0] mem_rdata;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         mon_en   = 1'b0;
  logic [7:0] wq[$];
  logic [3:0] rq[$];
  logic [3:0] ram     [16];
  logic [3:0] ref_ram [16];

  always #5 clk = ~clk;

  vga_tile_mem_arbiter #(
    .ADDR_W(c_AW), .DATA_W(c_DW), .FIFO_DEPTH(4), .CLR_VAL(c_CLR), .STALL_LIMIT(8)
  ) dut (
    .clk(clk), .RSTN(RSTN),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .in_blank(in_blank),
    .stall_flag(stall_flag), .fifo_level(fifo_level),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port RAM, registered read; contents seeded while reset is held.
  always @(posedge clk) begin
    if (!RSTN) begin
      for (int i = 0; i < 16; i++) ram[i] <= 4'(i);
      ram[5] <= 4'h9;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_req)
        check_eq("rd_grant", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, rd_addr});
      if (rd_valid) begin
        if (rq.size() == 0) check_eq("rd_unexpected", rd_valid, 0);
        else                check_eq("rd_data", rd_data, rq.pop_front());
      end
      if (mem_en && mem_we) begin
        if (wq.size() == 0) check_eq("wr_unexpected", mem_we, 0);
        else                check_eq("wr_addr_data", {mem_addr, mem_wdata}, wq.pop_front());
      end
    end
  end

  task automatic cyc(input bit rd, input logic [3:0] ra);
    @(posedge clk);
    #1;
    rd_req  = rd;
    rd_addr = ra;
    if (rd) rq.push_back(ref_ram[ra]);
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [3:0] d);
    wq.push_back({a, d});
    ref_ram[a] = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_ram[i] = 4'(i);
    ref_ram[5] = 4'h9;
    RSTN = 1'b0; rd_req = 1'b1; rd_addr = '0; wr_valid = 1'b1;
    wr_addr = 4'h1; wr_data = 4'h1; clr_req = 1'b0; in_blank = 1'b0;

    // Reset held 3 cycles with requests active
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_outputs",
               {rd_valid, wr_ready, clr_busy, stall_flag, fifo_level,
                mem_en, mem_we, mem_addr, mem_wdata}, 0);
    end
    cyc(0, 0);
    RSTN = 1'b1; wr_valid = 1'b0; in_blank = 1'b1;
    @(negedge clk);
    check_eq("wr_ready_after_rst", wr_ready, 1);
    mon_en = 1'b1;

    // Read latency
    cyc(1, 5);
    @(negedge clk);
    check_eq("rd_valid_early", rd_valid, 0);
    cyc(0, 0);
    @(negedge clk);
    check_eq("rd_valid_latency", rd_valid, 1);

    // Write held off while display reads
    cyc(1, 0);
    wr_valid = 1'b1; wr_addr = 4'h3; wr_data = 4'h7;
    expect_write(4'h3, 4'h7);
    @(negedge clk);
    check_eq("t3_level0", fifo_level, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0);
      wr_valid = 1'b0;
      @(negedge clk);
      check_eq("t3_held", {fifo_level, mem_we}, {3'd1, 1'b0});
    end
    cyc(0, 0);
    @(negedge clk);
    check_eq("t3_drain", {fifo_level, mem_we}, {3'd1, 1'b1});
    cyc(0, 0);
    @(negedge clk);
    check_eq("t3_level_after", fifo_level, 0);

    // Backpressure: 5 offers under continuous reads
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0);
      wr_valid = 1'b1; wr_addr = 4'(8 + i); wr_data = 4'(i + 1);
      @(negedge clk);
      check_eq("t4_wr_ready", wr_ready, (i < 4) ? 1 : 0);
      if (i < 4) expect_write(4'(8 + i), 4'(i + 1));
    end
    cyc(1, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    check_eq("t4_full", {fifo_level, wr_ready}, {3'd4, 1'b0});
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0);
      @(negedge clk);
      check_eq("t4_drain_consec", mem_we, 1);
    end
    cyc(0, 0);
    @(negedge clk);
    check_eq("t4_empty", {fifo_level, wr_ready}, {3'd0, 1'b1});
    check_eq("stall_before", stall_flag, 0);

    // Starved write sets the sticky stall flag after 8 cycles
`ifdef VBLANK_ONLY_EN
    cyc(0, 0);
    in_blank = 1'b0;
`else
    cyc(1, 5);
`endif
    wr_valid = 1'b1; wr_addr = 4'h6; wr_data = 4'hB;
    expect_write(4'h6, 4'hB);
    for (int j = 0; j < 9; j++) begin
`ifdef VBLANK_ONLY_EN
      cyc(0, 0);
`else
      cyc(1, 5);
`endif
      wr_valid = 1'b0;
      @(negedge clk);
      check_eq("t6_stall_flag", {mem_we, stall_flag}, {1'b0, (j == 8)});
    end
    cyc(0, 0);
    in_blank = 1'b1;
    @(negedge clk);
    check_eq("t6_release", {mem_we, stall_flag}, {1'b1, 1'b1});
    cyc(0, 0);
    @(negedge clk);
    check_eq("t6_sticky", {fifo_level, stall_flag}, {3'd0, 1'b1});

    // Full clear with a mid-clear push and an ignored clr_req
    cyc(0, 0);
    clr_req = 1'b1;
    @(negedge clk);
    check_eq("t5_busy_pre", clr_busy, 0);
    for (int i = 0; i < 16; i++) expect_write(4'(i), c_CLR);
    for (int c = 0; c < 16; c++) begin
      cyc(0, 0);
      clr_req  = (c == 8);
      wr_valid = (c == 3); wr_addr = 4'h2; wr_data = 4'hE;
      if (c == 3) expect_write(4'h2, 4'hE);
      @(negedge clk);
      check_eq("t5_clear_cycle", {clr_busy, mem_we}, {1'b1, 1'b1});
    end
    cyc(0, 0);
    clr_req = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check_eq("t5_after_clear", {clr_busy, mem_we}, {1'b0, 1'b1});

    // Read back cleared and overwritten tiles
    cyc(1, 2); @(negedge clk);
    cyc(1, 3); @(negedge clk);
    cyc(1, 4); @(negedge clk);
    cyc(0, 0); @(negedge clk);
    cyc(0, 0); @(negedge clk);
    check_eq("wq_empty", wq.size(), 0);
    check_eq("rq_empty", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
